run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/uproc_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/run_controller.sv | 149 ++++++++++++++
 tb/tb_run_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uproc_pkg.sv
// Shared types and constants for the micro-processor run controller.
package uproc_pkg;

  // Controller states. The numeric encoding is visible on the State port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  // Widest instruction word the controller is expected to see.
  localparam int HLT_MAX_W = 64;

  // HLT opcode is all ones; users slice the low INS_W bits.
  localparam logic [HLT_MAX_W-1:0] HLT_OPCODE = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles and holds at the all-ones value.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Synchronous clear; otherwise count up unless already at maximum.
  always_ff @(posedge clk) begin
    if (Reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run/step/halt controller for a two-cycle (FETCH, EXEC) micro-processor.
// Gates the decoder enables and the PC advance so that state only changes
// in EXEC, and stops cleanly on HaltReq, the HLT opcode or a breakpoint.
//
// Control inputs are level/pulse sampled at the rising edge of clk; there
// is no valid/ready handshake: Step and HaltReq are one-cycle pulses that
// are acted on in the cycle they are seen, Run is a level.
module run_controller
  import uproc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int INS_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Step,
  input  logic              HaltReq,
  input  logic              BpEn,
  input  logic [ADDR_W-1:0] BpAddr,
  input  logic [ADDR_W-1:0] PC_Addr,
  input  logic [INS_W-1:0]  Ins,
  input  logic              ID_RegCE,
  input  logic              ID_A_CE,
  input  logic              ID_CY_CE,
  output logic              Reg_CE,
  output logic              A_CE,
  output logic              CY_CE,
  output logic              PC_CE,
  output logic [1:0]        State,
  output logic              Halted,
  output logic              Busy,
  output logic [CNT_W-1:0]  InsCount
);

  run_state_e state_q, state_d;
  logic       single_q, single_d;        // current run is a single step
  logic       halt_pending_q, halt_pending_d;
  logic       bp_skip_q, bp_skip_d;      // let the breakpoint instruction run once
  logic       run_q;                     // Run from the previous cycle

  logic       is_hlt;
  logic       bp_hit;
  logic       in_exec;

  assign is_hlt = (Ins == HLT_OPCODE[INS_W-1:0]);
  assign bp_hit = BpEn && (PC_Addr == BpAddr) && !bp_skip_q;

  // State and control flag registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      single_q       <= 1'b0;
      halt_pending_q <= 1'b0;
      bp_skip_q      <= 1'b0;
      run_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      single_q       <= single_d;
      halt_pending_q <= halt_pending_d;
      bp_skip_q      <= bp_skip_d;
      run_q          <= Run;
    end
  end

  // Next-state and flag update logic.
  always_comb begin
    state_d        = state_q;
    single_d       = single_q;
    halt_pending_d = halt_pending_q;
    bp_skip_d      = bp_skip_q;
    case (state_q)
      ST_IDLE: begin
        if (HaltReq) begin
          state_d = ST_HALTED;
        end else if (Step) begin
          state_d  = ST_FETCH;
          single_d = 1'b1;
        end else if (Run) begin
          state_d  = ST_FETCH;
          single_d = 1'b0;
        end
      end
      ST_FETCH: begin
        // HLT is caught here so it never reaches EXEC and PC stays on it.
        if (HaltReq || halt_pending_q || is_hlt || bp_hit) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        bp_skip_d = 1'b0;
        if (HaltReq) begin
          halt_pending_d = 1'b1;
        end
        if (HaltReq || halt_pending_q) begin
          state_d = ST_HALTED;
        end else if (single_q) begin
          state_d  = ST_IDLE;
          single_d = 1'b0;
        end else if (Run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        // HaltReq is ignored here; only Step or a fresh Run resumes.
        if (Step) begin
          state_d   = ST_FETCH;
          single_d  = 1'b1;
          bp_skip_d = 1'b1;
        end else if (Run && !run_q) begin
          state_d   = ST_FETCH;
          single_d  = 1'b0;
          bp_skip_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if ((state_d == ST_HALTED) && (state_q != ST_HALTED)) begin
      halt_pending_d = 1'b0;
    end
  end

  // Enables are forced low while Reset is asserted, even mid-EXEC.
  assign in_exec = (state_q == ST_EXEC) && !Reset;
  assign Reg_CE  = in_exec && ID_RegCE;
  assign A_CE    = in_exec && ID_A_CE;
  assign CY_CE   = in_exec && ID_CY_CE;
  assign PC_CE   = in_exec;
  assign State   = state_q;
  assign Halted  = (state_q == ST_HALTED) && !Reset;
  assign Busy    = ((state_q == ST_FETCH) || (state_q == ST_EXEC)) && !Reset;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_ins_count (
    .clk  (clk),
    .Reset(Reset),
    .inc  (state_q == ST_EXEC),
    .count(InsCount)
  );

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed run/step/halt/breakpoint scenarios
// with a per-cycle expected-output queue and a simple program memory model.
module tb_run_controller;
  import uproc_pkg::*;

  localparam int ADDR_W = 5;
  localparam int INS_W  = 6;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              Reset, Run, Step, HaltReq, BpEn;
  logic [ADDR_W-1:0] BpAddr, PC_Addr;
  logic [INS_W-1:0]  Ins;
  logic              ID_RegCE, ID_A_CE, ID_CY_CE;
  logic              Reg_CE, A_CE, CY_CE, PC_CE, Halted, Busy;
  logic [1:0]        State;
  logic [CNT_W-1:0]  InsCount;

  logic              Reg_CE2, A_CE2, CY_CE2, PC_CE2, Halted2, Busy2;
  logic [1:0]        State2;
  logic [3:0]        InsCount2;

  // Program counter and program memory owned by the bench.
  logic [ADDR_W-1:0] pc;
  logic [INS_W-1:0]  prog_mem [32];
  assign PC_Addr = pc;
  assign Ins     = prog_mem[pc];

  always @(posedge clk) begin
    if (Reset) pc <= '0;
    else if (PC_CE) pc <= pc + 5'd1;
  end

  run_controller #(.ADDR_W(ADDR_W), .INS_W(INS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset), .Run(Run), .Step(Step), .HaltReq(HaltReq),
    .BpEn(BpEn), .BpAddr(BpAddr), .PC_Addr(PC_Addr), .Ins(Ins),
    .ID_RegCE(ID_RegCE), .ID_A_CE(ID_A_CE), .ID_CY_CE(ID_CY_CE),
    .Reg_CE(Reg_CE), .A_CE(A_CE), .CY_CE(CY_CE), .PC_CE(PC_CE),
    .State(State), .Halted(Halted), .Busy(Busy), .InsCount(InsCount)
  );

  // Narrow-counter instance for saturation.
  run_controller #(.ADDR_W(ADDR_W), .INS_W(INS_W), .CNT_W(4)) dut_sat (
    .clk(clk), .Reset(Reset), .Run(Run), .Step(Step), .HaltReq(HaltReq),
    .BpEn(BpEn), .BpAddr(BpAddr), .PC_Addr(PC_Addr), .Ins(Ins),
    .ID_RegCE(ID_RegCE), .ID_A_CE(ID_A_CE), .ID_CY_CE(ID_CY_CE),
    .Reg_CE(Reg_CE2), .A_CE(A_CE2), .CY_CE(CY_CE2), .PC_CE(PC_CE2),
    .State(State2), .Halted(Halted2), .Busy(Busy2), .InsCount(InsCount2)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];   // {State, PC_CE, Halted, Busy}

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: push the outputs expected for the state entered at this edge,
  // then compare after the edge.
  task automatic tick(input string tag, input logic [1:0] es);
    logic [4:0] e;
    exp_q.push_back({es, es == ST_EXEC, es == ST_HALTED,
                     (es == ST_FETCH) || (es == ST_EXEC)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, 32'({State, PC_CE, Halted, Busy}), 32'(e));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    Run = 0; Step = 0; HaltReq = 0; BpEn = 0; BpAddr = '0;
    ID_RegCE = 0; ID_A_CE = 0; ID_CY_CE = 0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    Reset = 1;
    tick({tag, "_rst"}, ST_IDLE);
    Reset = 0;
    check_eq({tag, "_rst_cnt"}, 32'(InsCount), 32'd0);
    check_eq({tag, "_rst_en"}, 32'({Reg_CE, A_CE, CY_CE, PC_CE}), 32'd0);
  endtask

  task automatic run_ticks(input string tag, input int n);
    for (int i = 1; i <= n; i++)
      tick($sformatf("%s_%0d", tag, i), (i % 2 == 1) ? ST_FETCH : ST_EXEC);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) prog_mem[i] = INS_W'($urandom_range(0, 62));
    idle_inputs();
    Reset = 1;
    @(posedge clk); #1;

    // Free run for 10 cycles.
    do_reset("run");
    Run = 1;
    run_ticks("run", 10);
    Run = 0;
    tick("run_stop", ST_IDLE);
    check_eq("run_cnt", 32'(InsCount), 32'd5);
    check_eq("run_pc", 32'(pc), 32'd5);

    // Single step from IDLE.
    do_reset("step");
    Step = 1;
    tick("step_f", ST_FETCH);
    Step = 0;
    tick("step_e", ST_EXEC);
    tick("step_i", ST_IDLE);
    tick("step_i2", ST_IDLE);
    check_eq("step_cnt", 32'(InsCount), 32'd1);
    check_eq("step_pc", 32'(pc), 32'd1);

    // Breakpoint at address 3, then step over it.
    do_reset("bp");
    BpEn = 1; BpAddr = 5'd3; Run = 1;
    run_ticks("bp", 7);
    tick("bp_hit", ST_HALTED);
    tick("bp_hold1", ST_HALTED);
    tick("bp_hold2", ST_HALTED);
    check_eq("bp_pc", 32'(pc), 32'd3);
    Run = 0;
    tick("bp_hold3", ST_HALTED);
    Step = 1;
    tick("bp_step_f", ST_FETCH);
    Step = 0;
    tick("bp_step_e", ST_EXEC);
    tick("bp_step_i", ST_IDLE);
    check_eq("bp_pc_after", 32'(pc), 32'd4);
    check_eq("bp_cnt", 32'(InsCount), 32'd4);
    BpEn = 0;

    // HaltReq during EXEC, ignored in HALTED, HaltReq in IDLE, Run rising edge.
    do_reset("hq");
    Run = 1; ID_A_CE = 1; ID_RegCE = 1; ID_CY_CE = 0;
    tick("hq_f", ST_FETCH);
    tick("hq_e", ST_EXEC);
    check_eq("hq_ens", 32'({Reg_CE, A_CE, CY_CE}), 32'b110);
    HaltReq = 1;
    tick("hq_halt", ST_HALTED);
    HaltReq = 0;
    check_eq("hq_a_off", 32'(A_CE), 32'd0);
    Run = 0; HaltReq = 1;
    tick("hq_ignored", ST_HALTED);
    HaltReq = 0;
    Step = 1;
    tick("hq_step_f", ST_FETCH);
    Step = 0;
    tick("hq_step_e", ST_EXEC);
    tick("hq_step_i", ST_IDLE);
    HaltReq = 1;
    tick("hq_idle_halt", ST_HALTED);
    HaltReq = 0;
    Run = 1;
    tick("hq_rise_f", ST_FETCH);
    tick("hq_rise_e", ST_EXEC);
    Run = 0;
    tick("hq_rise_i", ST_IDLE);
    check_eq("hq_cnt", 32'(InsCount), 32'd3);
    ID_A_CE = 0; ID_RegCE = 0;

    // HLT at address 2 never executes.
    prog_mem[2] = '1;
    do_reset("hlt");
    Run = 1;
    run_ticks("hlt", 5);
    tick("hlt_halt", ST_HALTED);
    tick("hlt_hold", ST_HALTED);
    check_eq("hlt_pc", 32'(pc), 32'd2);
    Run = 0;
    tick("hlt_low", ST_HALTED);
    Run = 1;
    tick("hlt_refetch", ST_FETCH);
    tick("hlt_rehalt", ST_HALTED);
    check_eq("hlt_pc2", 32'(pc), 32'd2);
    check_eq("hlt_cnt", 32'(InsCount), 32'd2);
    prog_mem[2] = '0;

    // Reset asserted mid-EXEC.
    do_reset("mid");
    Run = 1; ID_A_CE = 1;
    tick("mid_f", ST_FETCH);
    tick("mid_e", ST_EXEC);
    check_eq("mid_a_on", 32'(A_CE), 32'd1);
    Reset = 1;
    #1;
    check_eq("mid_during", 32'({PC_CE, A_CE, Busy, Halted}), 32'd0);
    tick("mid_rst", ST_IDLE);
    check_eq("mid_after_en", 32'({Reg_CE, A_CE, CY_CE, PC_CE}), 32'd0);
    check_eq("mid_cnt", 32'(InsCount), 32'd0);
    Reset = 0; Run = 0; ID_A_CE = 0;

    // Step and Run together: step wins, then free run resumes.
    do_reset("sr");
    Run = 1; Step = 1;
    tick("sr_f", ST_FETCH);
    Step = 0;
    tick("sr_e", ST_EXEC);
    tick("sr_i", ST_IDLE);
    tick("sr_f2", ST_FETCH);
    tick("sr_e2", ST_EXEC);
    Run = 0;
    tick("sr_i2", ST_IDLE);
    check_eq("sr_cnt", 32'(InsCount), 32'd2);

    // 34 instructions: PC wraps past 31, narrow counter saturates.
    do_reset("sat");
    Run = 1;
    run_ticks("sat", 68);
    Run = 0;
    tick("sat_stop", ST_IDLE);
    check_eq("sat_cnt16", 32'(InsCount), 32'd34);
    check_eq("sat_cnt4", 32'(InsCount2), 32'd15);
    check_eq("sat_pc_wrap", 32'(pc), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
